// File: rtl/rop3_feeder.sv
// Operand serialiser / result collector for one rop3 core.
// Runs the core's 3-cycle slot continuously and returns results in order.
module rop3_feeder #(
   parameter int N          = 1,
   parameter int OBUF_DEPTH = 2,
   parameter int TAGQ_DEPTH = 4
) (
   input  logic         clk,
   input  logic         srst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_mode,
   input  logic [N-1:0] in_p,
   input  logic [N-1:0] in_s,
   input  logic [N-1:0] in_d,
   output logic [N-1:0] core_bitmap,
   output logic [7:0]   core_mode,
   input  logic [N-1:0] core_result,
   input  logic         core_valid,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic         err
);

   localparam int OAW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
   localparam int OCW = $clog2(OBUF_DEPTH + 1);
   localparam int QAW = (TAGQ_DEPTH > 1) ? $clog2(TAGQ_DEPTH) : 1;
   localparam int QCW = $clog2(TAGQ_DEPTH + 1);
   localparam int LW  = $clog2(OBUF_DEPTH + TAGQ_DEPTH + 2);

   typedef enum logic [1:0] {PH_P = 2'd0, PH_S = 2'd1, PH_D = 2'd2} ph_t;

   ph_t            ph;
   logic [7:0]     h_mode;
   logic [N-1:0]   h_p, h_s, h_d;
   logic           h_real;

   logic           tq [TAGQ_DEPTH];
   logic [QAW-1:0] tq_rd, tq_wr;
   logic [QCW-1:0] tq_cnt, tq_real;

   logic [N-1:0]   ob [OBUF_DEPTH];
   logic [OAW-1:0] ob_rd, ob_wr;
   logic [OCW-1:0] ob_cnt;

   logic [LW-1:0]  load;
   logic           credit, accept, slot_end;
   logic           tq_full, tq_pop, tq_push, tq_head;
   logic           ob_full, ob_pop, ob_wr_en;

   function automatic logic [QAW-1:0] q_next(input logic [QAW-1:0] p);
      return (p == QAW'(TAGQ_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [OAW-1:0] o_next(input logic [OAW-1:0] p);
      return (p == OAW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // the slot in the holding register counts against credit before its tag is queued
   assign load     = LW'(h_real) + LW'(tq_real) + LW'(ob_cnt);
   assign credit   = load < LW'(OBUF_DEPTH);
   assign slot_end = (ph == PH_D);
   assign in_ready = slot_end & credit;
   assign accept   = in_valid & in_ready;

   assign tq_head  = tq[tq_rd];
   assign tq_full  = (tq_cnt == QCW'(TAGQ_DEPTH));
   assign tq_pop   = core_valid & (tq_cnt != '0);
   assign tq_push  = slot_end & (!tq_full | tq_pop);

   assign out_valid = (ob_cnt != '0);
   assign out_result = out_valid ? ob[ob_rd] : '0;
   assign ob_full  = (ob_cnt == OCW'(OBUF_DEPTH));
   assign ob_pop   = out_valid & out_ready;
   assign ob_wr_en = tq_pop & tq_head & (!ob_full | ob_pop);

   assign core_mode = h_mode;

   always_comb begin
      core_bitmap = '0;
      unique case (1'b1)
         (ph == PH_P): core_bitmap = h_p;
         (ph == PH_S): core_bitmap = h_s;
         (ph == PH_D): core_bitmap = h_d;
         default:      core_bitmap = '0;
      endcase
   end

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         ph      <= PH_P;
         h_mode  <= '0;
         h_p     <= '0;
         h_s     <= '0;
         h_d     <= '0;
         h_real  <= 1'b0;
         tq_rd   <= '0;
         tq_wr   <= '0;
         tq_cnt  <= '0;
         tq_real <= '0;
         ob_rd   <= '0;
         ob_wr   <= '0;
         ob_cnt  <= '0;
         err     <= 1'b0;
         for (int i = 0; i < TAGQ_DEPTH; i++) tq[i] <= 1'b0;
         for (int i = 0; i < OBUF_DEPTH; i++) ob[i] <= '0;
      end else begin
         ph <= slot_end ? PH_P : ph_t'(ph + 2'd1);

         if (slot_end) begin
            h_real <= accept;
            h_mode <= accept ? in_mode : 8'h00;
            h_p    <= accept ? in_p : '0;
            h_s    <= accept ? in_s : '0;
            h_d    <= accept ? in_d : '0;
         end

         if (tq_push) begin
            tq[tq_wr] <= h_real;
            tq_wr     <= q_next(tq_wr);
         end
         if (tq_pop) tq_rd <= q_next(tq_rd);
         tq_cnt  <= tq_cnt + QCW'(tq_push) - QCW'(tq_pop);
         tq_real <= tq_real + QCW'(tq_push & h_real)
                            - QCW'(tq_pop & tq_head);

         if (ob_wr_en) begin
            ob[ob_wr] <= core_result;
            ob_wr     <= o_next(ob_wr);
         end
         if (ob_pop) ob_rd <= o_next(ob_rd);
         ob_cnt <= ob_cnt + OCW'(ob_wr_en) - OCW'(ob_pop);

         if ((core_valid & (tq_cnt == '0)) | (slot_end & tq_full & !tq_pop))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rop3_feeder.sv
// Bench for rop3_feeder with a behavioural rop3 core (result = Mode[{P,S,D}]).
// Expected results are queued on acceptance and checked by a separate monitor.
module tb_rop3_feeder;

   logic       clk = 1'b0;
   logic       srst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_mode = '0;
   logic [0:0] in_p = '0, in_s = '0, in_d = '0;
   logic [0:0] core_bitmap;
   logic [7:0] core_mode;
   logic [0:0] core_result;
   logic       core_valid;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [0:0] out_result;
   logic       err;

   logic       cv, cres, cp, cs, inj = 1'b0;
   logic [1:0] cph;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic       sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rop3_feeder #(.N(1), .OBUF_DEPTH(2), .TAGQ_DEPTH(4)) dut (
      .clk(clk), .srst_n(srst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_p(in_p), .in_s(in_s), .in_d(in_d),
      .core_bitmap(core_bitmap), .core_mode(core_mode),
      .core_result(core_result), .core_valid(core_valid),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .err(err)
   );

   // behavioural core: own phase counter on the shared reset
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         cph <= 2'd0; cp <= 1'b0; cs <= 1'b0; cv <= 1'b0; cres <= 1'b0;
      end else begin
         cv  <= 1'b0;
         cph <= (cph == 2'd2) ? 2'd0 : cph + 2'd1;
         case (cph)
            2'd0: cp <= core_bitmap[0];
            2'd1: cs <= core_bitmap[0];
            default: begin
               cres <= core_mode[{cp, cs, core_bitmap[0]}];
               cv   <= 1'b1;
            end
         endcase
      end
   end
   assign core_valid  = cv | inj;
   assign core_result = cres;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (srst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else chk("result", {31'b0, out_result}, {31'b0, sb.pop_front()});
      end
   end

   task automatic send(input logic [7:0] m, input logic p, s, d,
                       output int acc_cyc);
      logic ok;
      logic [7:0] mm;
      int n;
      in_mode = m; in_p = p; in_s = s; in_d = d; in_valid = 1'b1;
      ok = 1'b0; n = 0; acc_cyc = -1;
      while (!ok && n < 60) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         n++;
      end
      if (ok) begin
         mm = m;
         sb.push_back(mm[{p, s, d}]);
         acc_cyc = cyc;
      end else chk("send_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(nm, sb.size(), 0);
   endtask

   task automatic wait_ph1();
      int n;
      n = 0;
      @(negedge clk);
      while (cph != 2'd1 && n < 10) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ac, prev, acc, got;
      logic [2:0] psd;

      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_core_bitmap", core_bitmap, 0);
      chk("rst_core_mode", core_mode, 0);
      chk("rst_out_result", out_result, 0);
      chk("rst_err", err, 0);
      @(posedge clk); @(posedge clk); #1;
      srst_n = 1'b1;

      repeat (30) begin
         @(negedge clk);
         chk("idle_out_valid", out_valid, 0);
         chk("idle_err", err, 0);
         chk("idle_core_bitmap", core_bitmap, 0);
      end
      @(posedge clk); #1;

      // single set: 8'h20 at index 5 -> 1
      send(8'h20, 1'b1, 1'b0, 1'b1, ac);
      @(negedge clk); chk("single_bm_p", core_bitmap, 1);
      chk("single_mode", core_mode, 8'h20);
      @(negedge clk); chk("single_bm_s", core_bitmap, 0);
      @(negedge clk); chk("single_bm_d", core_bitmap, 1);
      drain("single_drain");
      @(posedge clk); #1;
      send(8'hDF, 1'b1, 1'b0, 1'b1, ac);
      drain("single_df_drain");
      @(posedge clk); #1;

      // back-to-back, every mode and operand combination
      prev = -1;
      for (int m = 0; m < 256; m++) begin
         for (int c = 0; c < 8; c++) begin
            psd = 3'(c);
            send(8'(m), psd[2], psd[1], psd[0], ac);
            if (prev >= 0) chk("b2b_spacing", ac - prev, 3);
            prev = ac;
         end
      end
      drain("b2b_drain");
      @(posedge clk); #1;

      // backpressure: only OBUF_DEPTH sets fit
      out_ready = 1'b0;
      acc = 0;
      in_mode = 8'h80; in_p = 1'b1; in_s = 1'b1; in_d = 1'b1; in_valid = 1'b1;
      repeat (30) begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(in_mode[{in_p, in_s, in_d}]);
            acc++;
            @(posedge clk); #1;
            in_mode = 8'h7F;
         end
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc, 2);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready_low", in_ready, 0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      got = 0;
      for (int n = 0; n < 20 && got == 0; n++) begin
         @(negedge clk);
         if (in_ready) got = 1;
      end
      chk("bp_ready_back", got, 1);
      drain("bp_drain");

      // spurious core_valid while the tag queue is empty
      wait_ph1();
      chk("spur_err_before", err, 0);
      inj = 1'b1;
      @(posedge clk); #1;
      inj = 1'b0;
      @(negedge clk); chk("spur_err_set", err, 1);
      repeat (10) @(negedge clk);
      chk("spur_err_sticky", err, 1);
      @(posedge clk); #1;

      // reset mid-slot with two buffered results
      out_ready = 1'b0;
      send(8'hFF, 1'b1, 1'b1, 1'b1, ac);
      send(8'h00, 1'b0, 1'b0, 1'b0, ac);
      repeat (12) @(negedge clk);
      chk("mid_out_valid_pre", out_valid, 1);
      wait_ph1();
      srst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_bitmap", core_bitmap, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      srst_n = 1'b1;
      @(negedge clk); chk("rel_ph0_ready", in_ready, 0);
      @(negedge clk); chk("rel_ph1_ready", in_ready, 0);
      @(negedge clk); chk("rel_ph2_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("rel_no_stale", out_valid, 0);
      end
      chk("rel_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
